// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters.
// Trained from execute-stage resolution; also keeps perf counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pc_pred_f,
  input  logic        cflow_valid_e,
  input  logic        cflow_taken_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_jump_e,
  input  logic        mispredict_e,
  output logic [31:0] perf_cflow_cnt,
  output logic [31:0] perf_miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic [1:0]       ctr_e;
  logic [1:0]       ctr_nxt;
  logic             unused_pc_lsb;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[31:IDX_W+2];
  assign idx_e = pc_e[IDX_W+1:2];
  assign tag_e = pc_e[31:IDX_W+2];
  assign unused_pc_lsb = ^{pc_f[1:0], pc_e[1:0]};

  // Lookup on current state; same-cycle updates are not bypassed
  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_f = hit_f && ctr_q[idx_f][1];
    pc_pred_f    = pred_taken_f ? target_q[idx_f] : pc_f + 32'd4;
  end

  // Saturating counter step for the resolving entry
  always_comb begin
    hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_e   = ctr_q[idx_e];
    ctr_nxt = ctr_e;
    if (cflow_taken_e) begin
      if (ctr_e != 2'b11) ctr_nxt = ctr_e + 2'b01;
    end else begin
      if (ctr_e != 2'b00) ctr_nxt = ctr_e - 2'b01;
    end
  end

  // Valid bits and counters: train on hit, allocate on taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (cflow_valid_e) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_nxt;
      end else if (cflow_taken_e) begin
        valid_q[idx_e] <= 1'b1;
        ctr_q[idx_e]   <= 2'b10;
      end
    end
  end

  // Tag/target payload; any taken event rewrites both
  always_ff @(posedge clk) begin
    if (rst_n && cflow_valid_e && cflow_taken_e) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= pc_jump_e;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cflow_cnt <= '0;
      perf_miss_cnt  <= '0;
    end else begin
      if (cflow_valid_e && perf_cflow_cnt != 32'hFFFF_FFFF)
        perf_cflow_cnt <= perf_cflow_cnt + 32'd1;
      if (mispredict_e && perf_miss_cnt != 32'hFFFF_FFFF)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Hand-computed expectations; one checking task.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pc_pred_f;
  logic        cflow_valid_e;
  logic        cflow_taken_e;
  logic [31:0] pc_e;
  logic [31:0] pc_jump_e;
  logic        mispredict_e;
  logic [31:0] perf_cflow_cnt;
  logic [31:0] perf_miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .pc_pred_f      (pc_pred_f),
    .cflow_valid_e  (cflow_valid_e),
    .cflow_taken_e  (cflow_taken_e),
    .pc_e           (pc_e),
    .pc_jump_e      (pc_jump_e),
    .mispredict_e   (mispredict_e),
    .perf_cflow_cnt (perf_cflow_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cflow_valid_e = 1'b0;
    cflow_taken_e = 1'b0;
    pc_e          = 32'h0;
    pc_jump_e     = 32'h0;
    mispredict_e  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic train(input logic [31:0] pc,
                       input logic tk,
                       input logic [31:0] tgt);
    cflow_valid_e = 1'b1;
    cflow_taken_e = tk;
    pc_e          = pc;
    pc_jump_e     = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic look(input string tag,
                      input logic [31:0] pc,
                      input logic tk,
                      input logic [31:0] nxt);
    pc_f = pc;
    #1;
    check({tag, "_taken"}, {31'h0, pred_taken_f}, {31'h0, tk});
    check({tag, "_next"}, pc_pred_f, nxt);
  endtask

  initial begin
    pc_f = 32'h100;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    look("in_reset", 32'h100, 1'b0, 32'h104);

    do_reset();
    look("post_reset", 32'h100, 1'b0, 32'h104);
    check("rst_cflow", perf_cflow_cnt, 32'h0);
    check("rst_miss", perf_miss_cnt, 32'h0);

    // allocate, then walk the counter
    train(32'h100, 1'b1, 32'h40);
    look("alloc", 32'h100, 1'b1, 32'h40);
    train(32'h100, 1'b0, 32'h0);
    look("ctr01", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0);
    look("ctr00", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0);
    look("ctr00_sat", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h40);
    look("ctr01_up", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h40);
    look("ctr10_up", 32'h100, 1'b1, 32'h40);
    check("cnt_train", perf_cflow_cnt, 32'd6);

    // saturate high; hit-taken rewrites the target
    train(32'h100, 1'b1, 32'h48);
    train(32'h100, 1'b1, 32'h48);
    look("ctr11_tgt", 32'h100, 1'b1, 32'h48);
    train(32'h100, 1'b0, 32'h0);
    look("ctr11_dn", 32'h100, 1'b1, 32'h48);
    train(32'h100, 1'b1, 32'h48);

    // other index is independent; not-taken miss allocates nothing
    train(32'h104, 1'b1, 32'h200);
    look("idx1", 32'h104, 1'b1, 32'h200);
    look("idx0_kept", 32'h100, 1'b1, 32'h48);
    train(32'h404, 1'b0, 32'h0);
    look("nt_miss", 32'h404, 1'b0, 32'h408);
    look("nt_miss_idx1", 32'h104, 1'b1, 32'h200);

    // alias on index 0 evicts 0x100
    train(32'h200, 1'b1, 32'h80);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 32'h80);

    // same-cycle lookup and update: no bypass
    do_reset();
    look("rst_clears", 32'h200, 1'b0, 32'h204);
    pc_f          = 32'h100;
    cflow_valid_e = 1'b1;
    cflow_taken_e = 1'b1;
    pc_e          = 32'h100;
    pc_jump_e     = 32'h40;
    #1;
    look("same_cyc", 32'h100, 1'b0, 32'h104);
    tick();
    idle_inputs();
    look("same_nxt", 32'h100, 1'b1, 32'h40);

    // cflow_valid low ignores the other update inputs
    cflow_valid_e = 1'b0;
    cflow_taken_e = 1'b1;
    pc_e          = 32'h300;
    pc_jump_e     = 32'h500;
    tick();
    idle_inputs();
    look("no_valid", 32'h300, 1'b0, 32'h304);
    check("no_valid_cnt", perf_cflow_cnt, 32'd1);

    // reset in the middle of a training cycle
    cflow_valid_e = 1'b1;
    cflow_taken_e = 1'b1;
    pc_e          = 32'h104;
    pc_jump_e     = 32'h700;
    #2;
    rst_n = 1'b0;
    tick();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    look("mid_rst", 32'h104, 1'b0, 32'h108);
    check("mid_rst_cnt", perf_cflow_cnt, 32'h0);

    // perf counters
    do_reset();
    cflow_valid_e = 1'b1;
    mispredict_e  = 1'b1;
    repeat (5) tick();
    idle_inputs();
    check("cflow5", perf_cflow_cnt, 32'd5);
    check("miss5", perf_miss_cnt, 32'd5);
    mispredict_e = 1'b1;
    tick();
    idle_inputs();
    check("miss_only_c", perf_cflow_cnt, 32'd5);
    check("miss_only_m", perf_miss_cnt, 32'd6);

    @(negedge clk);
    force dut.perf_cflow_cnt = 32'hFFFF_FFFE;
    force dut.perf_miss_cnt  = 32'hFFFF_FFFE;
    #1;
    release dut.perf_cflow_cnt;
    release dut.perf_miss_cnt;
    #1;
    check("preload_c", perf_cflow_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      cflow_valid_e = 1'b1;
      mispredict_e  = 1'b1;
      tick();
      idle_inputs();
      check("sat_c", perf_cflow_cnt, 32'hFFFF_FFFF);
      check("sat_m", perf_miss_cnt, 32'hFFFF_FFFF);
    end

    // fall-through wraps
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped BTB with a 2-bit saturating counter per entry.
- Produces pred_taken_f / pc_pred_f for the fetch PC each cycle; these are carried down the pipe into the execute-stage branch resolution as pred_taken_d / pc_pred_d.
- Trained by the resolved control-flow result (cflow_valid, cflow_taken, jump target) from execute.
- Keeps saturating performance counters of resolved control-flow instructions and mispredicts.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, 2..1024.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_f  input  32  fetch PC to predict.
- pred_taken_f  output  1  prediction: taken.
- pc_pred_f  output  32  predicted next PC.
- cflow_valid_e  input  1  execute has a resolved branch/JAL/JALR this cycle (already 0 when stalled).
- cflow_taken_e  input  1  resolved direction.
- pc_e  input  32  PC of the resolving instruction.
- pc_jump_e  input  32  resolved target.
- mispredict_e  input  1  execute-stage mispredict flag.
- perf_cflow_cnt  output  32  count of cycles with cflow_valid_e=1.
- perf_miss_cnt  output  32  count of cycles with mispredict_e=1.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid (1), tag, target (32), ctr (2).
- Lookup is combinational from pc_f on current state.
  - hit = valid[idx] && tag match.
  - pred_taken_f = hit && ctr[idx][1].
  - pc_pred_f = pred_taken_f ? target[idx] : pc_f + 32'd4 (wraps modulo 2^32).
- Update on a rising edge when cflow_valid_e=1, using the index/tag of pc_e:
  - Hit, taken: ctr saturating +1 (max 2'b11); target <= pc_jump_e.
  - Hit, not taken: ctr saturating -1 (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite the entry (valid=1, tag, target=pc_jump_e, ctr=2'b10).
  - Miss, not taken: no state change.
- JAL/JALR train as ordinary taken events; no type distinction.
- Same-cycle lookup and update to the same index: lookup returns pre-update state. No bypass; the new state is visible from the next cycle.
- cflow_valid_e=0: no BTB change, regardless of the other update inputs.
- Perf counters:
  - +1 per cycle with cflow_valid_e=1 / mispredict_e=1 respectively; both can increment in the same cycle.
  - Saturate at 32'hFFFF_FFFF; no wrap.
- Reset (async assert, sync-safe deassert handled upstream):
  - All valid <= 0; all ctr <= 2'b01; tag/target need no reset.
  - perf counters <= 0.
  - Outputs during/after reset: pred_taken_f=0, pc_pred_f=pc_f+4.
  - Reset mid-training discards any in-flight update in that cycle.
- Sizing: storage is inferred flops; ENTRIES=64 must meet fetch-cycle timing.

Test Plan:
- Reset, then pc_f=0x0000_0100 -> pred_taken_f=0, pc_pred_f=0x0000_0104; both perf counters 0.
- Update pc_e=0x100, taken, pc_jump_e=0x0000_0040; next cycle pc_f=0x100 -> pred_taken_f=1, pc_pred_f=0x40 (ctr=10).
- Two not-taken updates at 0x100 (ctr 10->01->00) -> pred_taken_f=0; then one taken update -> ctr=01, still 0; a second taken update -> 1.
- Entry 0x100 trained (ctr=11); taken update at alias pc_e=0x200 (same index 0, different tag) with target 0x80 -> pc_f=0x100 misses (pred 0, pc_pred 0x104), pc_f=0x200 predicts 0x80.
- pc_f=0x100 and a taken update for 0x100 in the same cycle after reset -> that cycle pred_taken_f=0; next cycle 1.
- Hold cflow_valid_e=1 and mispredict_e=1 for 5 cycles -> both counters 5; preload to 0xFFFF_FFFE plus 3 events -> both stick at 0xFFFF_FFFF; pc_f=0xFFFF_FFFC untrained -> pc_pred_f=0x0000_0000.
